alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `alu_control` code produced by the ALU decoder (`{funct7b5, funct3}`) and returns a registered result over a valid/ready handshake. Add/sub/logic/compare complete in one cycle. Shifts run on a serial one-bit-per-cycle shifter, so the unit can stall the pipeline. It sits between the ID/EX register and the EX/MEM register, and a synchronous flush discards work in flight.

## Interface
- `XLEN`, 32, datapath width. Must be a power of two, at least 8.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous kill of any accepted or pending operation.
- `in_valid` input 1: operands and code presented.
- `in_ready` output 1: unit can accept this cycle.
- `alu_control` input 4: operation code, `{funct7b5, funct3}`.
- `op_a` input XLEN: operand A (rs1).
- `op_b` input XLEN: operand B (rs2 or immediate).
- `out_valid` output 1: `result` and `zero` valid.
- `out_ready` input 1: downstream consumes this cycle.
- `result` output XLEN: registered result.
- `zero` output 1: registered `result == 0`.

## Operation
- Codes:
  - `0000` ADD, `1000` SUB.
  - `0001` SLL, `0101` SRL, `1101` SRA.
  - `0010` SLT (signed), `0011` SLTU.
  - `0100` XOR, `0110` OR, `0111` AND.
- Bit 3 is significant only for funct3 `000` and `101`. For any other `1xxx` code, bit 3 is ignored (`1100` behaves as XOR).
- SLT and SLTU write 1 or 0, zero-extended to XLEN.
- Shift amount is `op_b[log2(XLEN)-1:0]`. Upper bits of `op_b` are ignored.
- ADD/SUB wrap modulo 2^XLEN. There is no overflow flag.
- FSM has three states: IDLE, SHIFT, DONE.
  - IDLE, accept, non-shift code → DONE. Result is computed combinationally and registered.
  - IDLE, accept, shift with amount 0 → DONE, `result = op_a`.
  - IDLE, accept, shift with amount n > 0 → SHIFT. Load the accumulator with `op_a` and the counter with n.
  - SHIFT: each cycle shift the accumulator by 1 (SLL: zero-fill; SRL: zero-fill; SRA: sign-fill) and decrement the counter. When the counter reaches 0, go to DONE.
  - DONE with `out_ready` → IDLE. If a new operation is accepted in the same cycle, go to that operation's next state.
- `in_ready = (state == IDLE) || (state == DONE && out_ready)`. Back-to-back single-cycle operations therefore sustain 1 per cycle.
- `out_valid = (state == DONE)`. `result` and `zero` stay stable while `out_valid && !out_ready`.
- `flush` has priority over everything. On the next edge state is IDLE, `out_valid` is 0, and any `in_valid` in the flush cycle is not accepted (`in_ready` is forced to 0 while `flush` is high).
- Reset values: state IDLE, `out_valid` 0, `result` 0, `zero` 1, `in_ready` 1 after reset deasserts. Counter and accumulator are 0.
- Reset asserted mid-shift aborts immediately (asynchronous). No result is produced.

## Timing
- Accept at edge k.
  - Non-shift, or shift by 0: `out_valid` at k+1.
  - Shift by n ≥ 1: `out_valid` at k+n+1.
- Maximum latency is XLEN (shift by XLEN-1).
- `in_ready` is low throughout SHIFT, and in DONE while `out_ready` is low.
- There is no combinational path from `in_valid`, `op_a` or `op_b` to any output. `in_ready` depends on `out_ready` and `flush` combinationally.

## Structure
- Shared package holds:
  - the `alu_control` code constants (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND);
  - the FSM state enum.
- The decoder and this unit both import the package. Code values are not duplicated.
- One sub-module, `alu_serial_shifter`, contains the accumulator, the counter, direction/arith control, a `busy` output and a `done` output.
- The top level holds the combinational single-cycle datapath, the FSM and the output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 → 0x80000000 at k+1. SUB 5 − 5 → 0, `zero` = 1. Back-to-back accepts sustain 1 per cycle with `out_ready` held at 1.
- SLT(0xFFFFFFFF, 1) → 1. SLTU(0xFFFFFFFF, 1) → 0. AND/OR/XOR of 0xF0F0F0F0 and 0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00. Code `1100` gives the XOR result.
- SRA 0x80000000 by 31 → 0xFFFFFFFF at k+32, with `in_ready` low for k+1..k+31. SRL of the same operands → 0x00000001. SLL 1 by `op_b` = 0x00000024 (amount 4) → 0x10, `out_valid` at k+5.
- Shift by 0 → `op_a` at k+1. Hold `out_ready` = 0 for 3 cycles: `result` stays stable and `in_ready` stays 0, then accept proceeds on release.
- `flush` during SHIFT and during DONE → IDLE next cycle, `out_valid` = 0, and a concurrent `in_valid` is not accepted.
- Assert `rst` mid-shift → outputs go to their reset values asynchronously. The next operation after release behaves normally.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM states and
// code helpers used by both the ALU decoder and the execution unit.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  // funct7b5 only matters for ADD/SUB and SRL/SRA; fold it away elsewhere
  function automatic logic [3:0] alu_norm(input logic [3:0] code);
    if (code[2:0] == 3'b000 || code[2:0] == 3'b101) return code;
    return {1'b0, code[2:0]};
  endfunction

  function automatic logic alu_is_shift(input logic [3:0] code);
    logic [3:0] n;
    n = alu_norm(code);
    return (n == ALU_SLL) || (n == ALU_SRL) || (n == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: accumulator plus remaining-step counter.
// done flags the cycle whose shift step is the last one; acc_next_c is that step's value.
module alu_serial_shifter #(
  parameter int unsigned XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     start,
  input  logic                     left,
  input  logic                     arith,
  input  logic [XLEN-1:0]          data,
  input  logic [$clog2(XLEN)-1:0]  amount,
  output logic                     busy,
  output logic                     done,
  output logic [XLEN-1:0]          acc_next_c
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;
  logic            left_q;
  logic            arith_q;

  always_comb begin
    acc_next_c = {arith_q & acc[XLEN-1], acc[XLEN-1:1]};
    if (left_q) acc_next_c = {acc[XLEN-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (start) begin
      acc     <= data;
      cnt     <= amount;
      left_q  <= left;
      arith_q <= arith;
    end else if (cnt != '0) begin
      acc <= acc_next_c;
      cnt <= cnt - SHW'(1);
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == SHW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake: single-cycle arithmetic/logic,
// serial shifts via alu_serial_shifter, registered result and zero flag.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_state_t      state;
  alu_state_t      state_n;
  logic [3:0]      code;
  logic [SHW-1:0]  amount;
  logic [XLEN-1:0] alu_c;
  logic [XLEN-1:0] res_n;
  logic [XLEN-1:0] sh_next;
  logic            accept;
  logic            load_res;
  logic            sh_start;
  logic            sh_busy;
  logic            sh_done;

  assign code     = alu_norm(alu_control);
  assign amount   = op_b[SHW-1:0];
  assign in_ready = !flush && ((state == ST_IDLE) || (state == ST_DONE && out_ready));
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath; a zero-amount shift falls through to op_a
  always_comb begin
    alu_c = op_a;
    case (code)
      ALU_ADD:  alu_c = op_a + op_b;
      ALU_SUB:  alu_c = op_a - op_b;
      ALU_SLT:  alu_c = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_c = XLEN'(op_a < op_b);
      ALU_XOR:  alu_c = op_a ^ op_b;
      ALU_OR:   alu_c = op_a | op_b;
      ALU_AND:  alu_c = op_a & op_b;
      default:  alu_c = op_a;
    endcase
  end

  alu_serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .start      (sh_start),
    .left       (code == ALU_SLL),
    .arith      (code == ALU_SRA),
    .data       (op_a),
    .amount     (amount),
    .busy       (sh_busy),
    .done       (sh_done),
    .acc_next_c (sh_next)
  );

  always_comb begin
    state_n  = state;
    load_res = 1'b0;
    res_n    = alu_c;
    sh_start = 1'b0;
    case (state)
      ST_IDLE: state_n = ST_IDLE;
      ST_SHIFT: begin
        if (sh_done) begin
          state_n  = ST_DONE;
          load_res = 1'b1;
          res_n    = sh_next;
        end else if (!sh_busy) begin
          state_n = ST_IDLE;
        end
      end
      ST_DONE: if (out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // accept is only possible from IDLE or a draining DONE
    if (accept) begin
      if (alu_is_shift(alu_control) && amount != '0) begin
        state_n  = ST_SHIFT;
        sh_start = 1'b1;
      end else begin
        state_n  = ST_DONE;
        load_res = 1'b1;
        res_n    = alu_c;
      end
    end
    if (flush) begin
      state_n  = ST_IDLE;
      load_res = 1'b0;
      sh_start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == ST_DONE);
      if (load_res) begin
        result <= res_n;
        zero   <= (res_n == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: latency-based reference model checked
// every cycle, plus directed cases with hand-computed expectations.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int tests = 0;
  int fails = 0;

  bit          m_valid;
  int          m_wait;
  logic [31:0] m_res;
  logic [31:0] m_pend;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural meaning of each code, straight from the instruction semantics
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned       sh;
    logic signed [31:0] sa;
    logic [31:0]       r;
    sh = int'(b[4:0]);
    sa = a;
    case (c[2:0])
      3'd0: r = c[3] ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: if (c[3]) r = sa >>> sh; else r = a >> sh;
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic int ref_cycles(input logic [3:0] c, input logic [31:0] b);
    if (c[1:0] == 2'b01) return int'(b[4:0]);
    return 0;
  endfunction

  function automatic bit model_ready();
    return !flush && ((!m_valid && m_wait == 0) || (m_valid && out_ready));
  endfunction

  // Reference model: a pending result becomes visible after its shift count of edges
  initial begin
    m_valid = 0; m_wait = 0; m_res = '0; m_pend = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_valid = 0; m_wait = 0; m_res = '0;
      end else begin
        bit acc_now;
        int n;
        acc_now = model_ready() && in_valid;
        if (flush) begin
          m_valid = 0; m_wait = 0;
        end else begin
          if (m_wait != 0) begin
            m_wait--;
            if (m_wait == 0) begin m_valid = 1; m_res = m_pend; end
          end else if (m_valid && out_ready) begin
            m_valid = 0;
          end
          if (acc_now) begin
            n = ref_cycles(alu_control, op_b);
            if (n == 0) begin
              m_valid = 1; m_res = ref_alu(alu_control, op_a, op_b);
            end else begin
              m_valid = 0; m_wait = n; m_pend = ref_alu(alu_control, op_a, op_b);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("model in_ready", 32'(in_ready), 32'(model_ready()));
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("model result", result, m_res);
        chk("model zero", 32'(zero), 32'(m_res == 32'd0));
      end
    end
  end

  task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int g;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; alu_control = c; op_a = a; op_b = b; out_ready = 1'b1;
    #1;
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); #1; g++; end
    if (g >= 100) chk({name, " accept timeout"}, 32'(g), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); #1; lat++; end
    chk({name, " result"}, result, exp);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = ALU_ADD; op_a = '0; op_b = '0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", 32'(zero), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);

    run_op("add wrap", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    run_op("sub zero", ALU_SUB, 32'd5, 32'd5, 32'd0, 1);
    chk("sub zero flag", 32'(zero), 32'd1);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("and", ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1);
    run_op("or", ALU_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1);
    run_op("xor", ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1);
    run_op("xor alias", 4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1);
    run_op("sra 31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    run_op("srl 31", ALU_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    run_op("sll 4", ALU_SLL, 32'd1, 32'h0000_0024, 32'h0000_0010, 5);

    // back-to-back single-cycle throughput
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        in_valid = 1'b1; alu_control = ALU_ADD; op_a = 32'(i); op_b = 32'd10;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 4) chk("b2b in_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        chk("b2b out_valid", 32'(out_valid), 32'd1);
        chk("b2b result", result, 32'(i - 1 + 10));
      end
    end

    // zero-amount shift, then backpressure for three cycles
    @(negedge clk);
    in_valid = 1'b1; alu_control = ALU_SLL; op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0020;
    out_ready = 1'b0;
    @(negedge clk);
    alu_control = ALU_ADD; op_a = 32'd1; op_b = 32'd2;
    #1;
    chk("shift0 out_valid", 32'(out_valid), 32'd1);
    chk("shift0 result", result, 32'hDEAD_BEEF);
    chk("hold in_ready", 32'(in_ready), 32'd0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("hold result", result, 32'hDEAD_BEEF);
      chk("hold in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("release out_valid", 32'(out_valid), 32'd1);
    chk("release result", result, 32'd3);

    // flush while shifting, with a concurrent request
    @(negedge clk);
    in_valid = 1'b1; alu_control = ALU_SRL; op_a = 32'hFFFF_0000; op_b = 32'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; alu_control = ALU_ADD; op_a = 32'd4; op_b = 32'd4;
    #1;
    chk("flush shift in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush shift out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    chk("flush shift no accept", 32'(out_valid), 32'd0);
    repeat (12) @(negedge clk);

    // flush while holding a result
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = ALU_ADD; op_a = 32'd1; op_b = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("flush done pre valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; alu_control = ALU_XOR;
    #1;
    chk("flush done in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush done out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    chk("flush done no accept", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // asynchronous reset in the middle of a shift
    @(negedge clk);
    in_valid = 1'b1; alu_control = ALU_SLL; op_a = 32'd1; op_b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst result", result, 32'd0);
    chk("async rst zero", 32'(zero), 32'd1);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    run_op("post rst add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1);

    // randomized traffic, checked each cycle by the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 40) == 0);
      alu_control = 4'($urandom_range(0, 15));
      op_a        = $urandom;
      op_b        = $urandom;
      if ($urandom_range(0, 1) == 1) op_b[4:0] = 5'($urandom_range(0, 3));
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
